wb_data_port_bridge: RTL and testbench
======================================

// Module: wb_data_port_bridge
// PURPOSE
//  Converts the core's single-request data port (req/wen_n/wmask/addr/data, stall) into
//  pipelined Wishbone single transfers for the second (data) memory in processorci_top.
//  It sits between the core's data interface and the data_mem_* bus.
//  It generates data_stall_i back to the core. It optionally registers the response path.
//  It aborts with an error pulse on bus timeout.
// PARAMETERS
//  ADDR_WIDTH      32   address width, both sides
//  DATA_WIDTH      32   data width; SEL width = DATA_WIDTH/8
//  REG_RESP        1    1: register wb_ack_i/wb_dat_i one cycle before use; 0: use directly
//  TIMEOUT_CYCLES  255  max cycles from STB acceptance to ACK; 0 disables the timeout
// PORTS
//  clk_core        in   1     core clock
//  rst_core        in   1     asynchronous, active-high reset
//  data_req_i      in   1     core request; held with all fields stable while data_stall_o=1
//  data_wen_n_i    in   1     0 = write, 1 = read (core polarity)
//  data_wmask_i    in   SEL   byte mask (writes)
//  data_addr_i     in   AW    byte address
//  data_wdata_i    in   DW    write data
//  data_stall_o    out  1     1 = bridge busy, request not accepted
//  data_rdata_o    out  DW    read data, held until next read completes
//  data_rvalid_o   out  1     1-cycle pulse: transfer (read or write) completed OK
//  data_err_o      out  1     1-cycle pulse: transfer aborted by timeout
//  wb_cyc_o        out  1     Wishbone cycle
//  wb_stb_o        out  1     Wishbone strobe (pipelined: one accepted beat)
//  wb_we_o         out  1     1 = write
//  wb_sel_o        out  SEL   byte selects (all ones on reads)
//  wb_adr_o        out  AW    address
//  wb_dat_o        out  DW    write data
//  wb_dat_i        in   DW    read data
//  wb_ack_i        in   1     transfer acknowledge
//  wb_stall_i      in   1     slave stall; STB not accepted while 1
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (incl. data_rdata_o); timeout counter 0; ack/dat regs 0.
//  Reset mid-transfer drops cyc/stb immediately (async). The aborted transfer gives no rvalid or err.
//  Busy: data_stall_o = (state != IDLE), registered-state decode. No combinational req->stall path.
//  States:
//   IDLE  : a request with req=1 is accepted at the clock edge. Addr/data/mask/we are latched.
//           we = ~data_wen_n_i. Read: sel = all ones.
//           Write with wmask==0: no bus cycle. Go to DONE.
//           Otherwise go to ISSUE.
//   ISSUE : cyc=1, stb=1. Stay in ISSUE while wb_stall_i=1.
//           On wb_stall_i=0, go to WAIT. The timeout counter clears.
//           If an ack (used ack, see REG_RESP) is seen in the same cycle, go directly to DONE.
//   WAIT  : cyc=1, stb=0. On used ack, capture the read data (reads only) and go to DONE.
//           The timeout counter increments each WAIT cycle.
//           When count==TIMEOUT_CYCLES-1 with no ack: go to IDLE, pulse data_err_o, drop cyc.
//   DONE  : data_rvalid_o=1 for this single cycle; data_rdata_o is valid. Next state is IDLE.
//  Used ack / data: with REG_RESP=1, ack_q and dat_q sample wb_ack_i and wb_dat_i every cycle.
//  With REG_RESP=0, the raw inputs are used.
//  Stray acks: an ack while cyc=0, in IDLE, or after timeout is ignored. Covers a registered
//  ack arriving after the abort. A write never modifies data_rdata_o.
//  Latency (read accepted in cycle T, no slave stall, ack in cycle T+2):
//   REG_RESP=1: stb in T+1, rvalid in T+4, stall_o high T+1..T+4.
//   REG_RESP=0: rvalid in T+3.
//  Back-to-back: the next request can be accepted in the cycle after DONE (first IDLE cycle).
//  Only one transfer is outstanding at a time. The wb_* outputs are stable from ISSUE to cyc drop.
// TESTING
//  1 Read, REG_RESP=1: addr 0x100, slave acks at T+2 with 0xDEADBEEF
//    -> stb only in T+1, rvalid=1 in T+4, rdata=0xDEADBEEF.
//  2 Write wmask=4'b0011, data 0x12345678 to 0x40
//    -> we=1, sel=0011, adr=0x40, dat_o=0x12345678, rvalid pulse, rdata unchanged.
//  3 wb_stall_i=1 for 3 cycles during ISSUE -> stb held 4 cycles, fields stable, one ack completes.
//  4 TIMEOUT_CYCLES=8, no ack -> err pulse 8 WAIT cycles after stb accepted, cyc=0, IDLE.
//    A late ack 2 cycles later -> no rvalid.
//  5 Write with wmask=0 -> cyc never asserted, rvalid one cycle after accept.
//  6 Assert rst_core during WAIT -> cyc/stb/stall go 0 asynchronously.
//    After release, a read 0x200 completes normally.

Source files
------------

// File: rtl/wb_data_port_bridge.sv
// Core data port to pipelined Wishbone single-transfer bridge.
// One transfer in flight; optional response register; bus timeout abort.
module wb_data_port_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int REG_RESP       = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_core,
   input  logic                      rst_core,
   input  logic                      data_req_i,
   input  logic                      data_wen_n_i,
   input  logic [DATA_WIDTH/8-1:0]   data_wmask_i,
   input  logic [ADDR_WIDTH-1:0]     data_addr_i,
   input  logic [DATA_WIDTH-1:0]     data_wdata_i,
   output logic                      data_stall_o,
   output logic [DATA_WIDTH-1:0]     data_rdata_o,
   output logic                      data_rvalid_o,
   output logic                      data_err_o,
   output logic                      wb_cyc_o,
   output logic                      wb_stb_o,
   output logic                      wb_we_o,
   output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
   output logic [ADDR_WIDTH-1:0]     wb_adr_o,
   output logic [DATA_WIDTH-1:0]     wb_dat_o,
   input  logic [DATA_WIDTH-1:0]     wb_dat_i,
   input  logic                      wb_ack_i,
   input  logic                      wb_stall_i
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  to_cnt;
   logic                  ack_use;
   logic [DATA_WIDTH-1:0] dat_use;
   logic                  timeout_hit;

   generate
      if (REG_RESP != 0) begin : g_reg_resp
         logic                  ack_q;
         logic [DATA_WIDTH-1:0] dat_q;

         // Register the slave response one cycle before the FSM looks at it
         always_ff @(posedge clk_core or posedge rst_core) begin
            if (rst_core) begin
               ack_q <= 1'b0;
               dat_q <= '0;
            end else begin
               ack_q <= wb_ack_i;
               dat_q <= wb_dat_i;
            end
         end

         assign ack_use = ack_q;
         assign dat_use = dat_q;
      end else begin : g_raw_resp
         assign ack_use = wb_ack_i;
         assign dat_use = wb_dat_i;
      end
   endgenerate

   assign timeout_hit  = TIMEOUT_ON && (to_cnt == CNT_LAST);
   assign data_stall_o = (state != S_IDLE);

   // Transfer sequencer; all bus and core-side outputs are registered here
   always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
         state         <= S_IDLE;
         to_cnt        <= '0;
         wb_cyc_o      <= 1'b0;
         wb_stb_o      <= 1'b0;
         wb_we_o       <= 1'b0;
         wb_sel_o      <= '0;
         wb_adr_o      <= '0;
         wb_dat_o      <= '0;
         data_rdata_o  <= '0;
         data_rvalid_o <= 1'b0;
         data_err_o    <= 1'b0;
      end else begin
         data_rvalid_o <= 1'b0;
         data_err_o    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (data_req_i) begin
                  wb_we_o  <= ~data_wen_n_i;
                  wb_adr_o <= data_addr_i;
                  wb_dat_o <= data_wdata_i;
                  wb_sel_o <= data_wen_n_i ? {SEL_WIDTH{1'b1}}
                                           : data_wmask_i;
                  if (!data_wen_n_i && (data_wmask_i == '0)) begin
                     // Empty write: nothing to put on the bus
                     state         <= S_DONE;
                     data_rvalid_o <= 1'b1;
                  end else begin
                     state    <= S_ISSUE;
                     wb_cyc_o <= 1'b1;
                     wb_stb_o <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (!wb_stall_i) begin
                  wb_stb_o <= 1'b0;
                  to_cnt   <= '0;
                  if (ack_use) begin
                     wb_cyc_o      <= 1'b0;
                     state         <= S_DONE;
                     data_rvalid_o <= 1'b1;
                     if (!wb_we_o) begin
                        data_rdata_o <= dat_use;
                     end
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (ack_use) begin
                  wb_cyc_o      <= 1'b0;
                  state         <= S_DONE;
                  data_rvalid_o <= 1'b1;
                  if (!wb_we_o) begin
                     data_rdata_o <= dat_use;
                  end
               end else if (timeout_hit) begin
                  wb_cyc_o   <= 1'b0;
                  state      <= S_IDLE;
                  data_err_o <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_data_port_bridge.sv
// Bench for wb_data_port_bridge: transaction-timeline model plus
// directed transfers covering read, write, stall, timeout, empty write, reset.
module tb_wb_data_port_bridge;

   localparam int TO = 8;

   logic        clk_core = 1'b0;
   logic        rst_core = 1'b1;
   logic        data_req_i;
   logic        data_wen_n_i;
   logic [3:0]  data_wmask_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_stall_o;
   logic [31:0] data_rdata_o;
   logic        data_rvalid_o;
   logic        data_err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_stall_i;

   wb_data_port_bridge #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .REG_RESP       (1),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_core      (clk_core),
      .rst_core      (rst_core),
      .data_req_i    (data_req_i),
      .data_wen_n_i  (data_wen_n_i),
      .data_wmask_i  (data_wmask_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_stall_o  (data_stall_o),
      .data_rdata_o  (data_rdata_o),
      .data_rvalid_o (data_rvalid_o),
      .data_err_o    (data_err_o),
      .wb_cyc_o      (wb_cyc_o),
      .wb_stb_o      (wb_stb_o),
      .wb_we_o       (wb_we_o),
      .wb_sel_o      (wb_sel_o),
      .wb_adr_o      (wb_adr_o),
      .wb_dat_o      (wb_dat_o),
      .wb_dat_i      (wb_dat_i),
      .wb_ack_i      (wb_ack_i),
      .wb_stall_i    (wb_stall_i)
   );

   always #5 clk_core = ~clk_core;

   int cycle   = 0;
   int n_pass  = 0;
   int n_total = 0;

   // Current transaction as the model sees it
   bit          tx_v = 1'b0;
   bit          tx_we;
   bit          tx_bus;
   int          tx_T;
   int          tx_S;
   int          tx_d;
   logic [3:0]  tx_sel;
   logic [31:0] tx_adr;
   logic [31:0] tx_dat;
   logic [31:0] tx_rdat;
   logic [31:0] prev_rdata = '0;
   int          late_ack = -1;

   function automatic bit tx_timeout();
      return tx_v && tx_bus && (tx_d == 0);
   endfunction

   function automatic int tx_P();
      return tx_T + 1 + tx_S;
   endfunction

   function automatic int tx_done();
      return !tx_bus ? tx_T + 1 : tx_P() + tx_d + 2;
   endfunction

   function automatic int tx_last_busy();
      return tx_timeout() ? tx_P() + TO : tx_done();
   endfunction

   function automatic logic [31:0] final_rdata();
      return (tx_v && !tx_we && tx_bus && tx_d > 0) ? tx_rdat : prev_rdata;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s @cycle %0d: got %h expected %h",
                  nm, cycle, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk_core);
      #1;
      cycle++;
      data_req_i = 1'b0;
      wb_stall_i = tx_v && tx_bus && cycle >= tx_T + 1 &&
                   cycle <= tx_T + tx_S;
      wb_ack_i   = (tx_v && tx_bus && tx_d > 0 &&
                    cycle == tx_P() + tx_d) || (cycle == late_ack);
      wb_dat_i   = wb_ack_i ? tx_rdat : (32'hBAD0_0000 ^ 32'(cycle));
   endtask

   task automatic start_tx(input bit we, input logic [3:0] mask,
                           input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input int s, input int d,
                           input logic [31:0] rdat);
      tick();
      prev_rdata   = final_rdata();
      tx_v         = 1'b1;
      tx_we        = we;
      tx_bus       = !(we && mask == 4'h0);
      tx_T         = cycle;
      tx_S         = s;
      tx_d         = d;
      tx_sel       = we ? mask : 4'hF;
      tx_adr       = addr;
      tx_dat       = wdata;
      tx_rdat      = rdat;
      data_req_i   = 1'b1;
      data_wen_n_i = !we;
      data_wmask_i = mask;
      data_addr_i  = addr;
      data_wdata_i = wdata;
   endtask

   task automatic wait_tx();
      int stop_at;
      stop_at = tx_last_busy() + (tx_timeout() ? 1 : 0);
      while (cycle < stop_at) tick();
   endtask

   // Per-cycle comparison of every DUT output against the timeline model
   always @(negedge clk_core) begin
      int  c;
      bit  e_stall, e_cyc, e_stb, e_rv, e_err;
      logic [31:0] e_rd;
      if (rst_core) begin
         chk("rst_stall", data_stall_o, 0);
         chk("rst_cyc", wb_cyc_o, 0);
         chk("rst_stb", wb_stb_o, 0);
         chk("rst_rvalid", data_rvalid_o, 0);
         chk("rst_err", data_err_o, 0);
         chk("rst_rdata", data_rdata_o, 0);
      end else begin
         c       = cycle;
         e_stall = tx_v && c >= tx_T + 1 && c <= tx_last_busy();
         e_cyc   = tx_v && tx_bus && c >= tx_T + 1 &&
                   c <= (tx_timeout() ? tx_P() + TO : tx_done() - 1);
         e_stb   = tx_v && tx_bus && c >= tx_T + 1 && c <= tx_P();
         e_rv    = tx_v && !tx_timeout() && c == tx_done();
         e_err   = tx_timeout() && c == tx_P() + TO + 1;
         e_rd    = (tx_v && !tx_we && tx_bus && tx_d > 0 &&
                    c >= tx_done()) ? tx_rdat : prev_rdata;
         chk("stall", data_stall_o, e_stall);
         chk("cyc", wb_cyc_o, e_cyc);
         chk("stb", wb_stb_o, e_stb);
         chk("rvalid", data_rvalid_o, e_rv);
         chk("err", data_err_o, e_err);
         chk("rdata", data_rdata_o, e_rd);
         if (e_cyc) begin
            chk("we", wb_we_o, tx_we);
            chk("sel", wb_sel_o, tx_sel);
            chk("adr", wb_adr_o, tx_adr);
            if (tx_we) chk("dat_o", wb_dat_o, tx_dat);
         end
      end
   end

   initial begin
      data_req_i   = 1'b0;
      data_wen_n_i = 1'b1;
      data_wmask_i = 4'h0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      wb_dat_i     = '0;
      wb_ack_i     = 1'b0;
      wb_stall_i   = 1'b0;

      repeat (2) @(posedge clk_core);
      #1;
      chk("reset_cyc", wb_cyc_o, 0);
      chk("reset_rdata", data_rdata_o, 0);
      chk("reset_stall", data_stall_o, 0);
      rst_core = 1'b0;
      tick();

      // Read 0x100, ack two cycles after accept
      start_tx(0, 4'h0, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF);
      tick();
      chk("t1_stb_T1", wb_stb_o, 1);
      chk("t1_adr_T1", wb_adr_o, 32'h100);
      chk("t1_sel_T1", wb_sel_o, 4'hF);
      tick();
      chk("t1_stb_T2", wb_stb_o, 0);
      tick();
      chk("t1_rvalid_T3", data_rvalid_o, 0);
      tick();
      chk("t1_rvalid_T4", data_rvalid_o, 1);
      chk("t1_rdata_T4", data_rdata_o, 32'hDEAD_BEEF);
      chk("t1_stall_T4", data_stall_o, 1);
      tick();
      chk("t1_stall_T5", data_stall_o, 0);

      // Partial write; slave drives junk on dat_i with the ack
      start_tx(1, 4'b0011, 32'h40, 32'h1234_5678, 0, 1, 32'h0BAD_F00D);
      tick();
      chk("t2_we", wb_we_o, 1);
      chk("t2_sel", wb_sel_o, 4'b0011);
      chk("t2_adr", wb_adr_o, 32'h40);
      chk("t2_dat", wb_dat_o, 32'h1234_5678);
      wait_tx();
      chk("t2_rvalid", data_rvalid_o, 1);
      chk("t2_rdata_kept", data_rdata_o, 32'hDEAD_BEEF);

      // Slave stalls three cycles
      start_tx(0, 4'h0, 32'h80, 32'h0, 3, 2, 32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_stb_held", wb_stb_o, 1);
         chk("t3_adr_held", wb_adr_o, 32'h80);
      end
      tick();
      chk("t3_stb_drop", wb_stb_o, 0);
      wait_tx();
      chk("t3_rdata", data_rdata_o, 32'hCAFE_F00D);

      // No ack: timeout, then a late stray ack
      start_tx(0, 4'h0, 32'h300, 32'h0, 0, 0, 32'h7777_7777);
      late_ack = tx_T + 12;
      repeat (9) tick();
      chk("t4_err_T9", data_err_o, 0);
      chk("t4_cyc_T9", wb_cyc_o, 1);
      tick();
      chk("t4_err_T10", data_err_o, 1);
      chk("t4_cyc_T10", wb_cyc_o, 0);
      chk("t4_stall_T10", data_stall_o, 0);
      repeat (4) tick();
      chk("t4_late_rvalid", data_rvalid_o, 0);
      chk("t4_rdata", data_rdata_o, 32'hCAFE_F00D);

      // Empty write, then back-to-back read
      start_tx(1, 4'h0, 32'h44, 32'hFFFF_FFFF, 0, 0, 32'h0);
      chk("t5_cyc_T", wb_cyc_o, 0);
      tick();
      chk("t5_rvalid_T1", data_rvalid_o, 1);
      chk("t5_cyc_T1", wb_cyc_o, 0);
      start_tx(0, 4'h0, 32'h104, 32'h0, 1, 3, 32'h0A0B_0C0D);
      chk("b2b_stall_accept", data_stall_o, 0);
      wait_tx();
      chk("b2b_rdata", data_rdata_o, 32'h0A0B_0C0D);

      // Reset while waiting for an ack
      start_tx(0, 4'h0, 32'h208, 32'h0, 0, 5, 32'h1357_9BDF);
      late_ack = tx_T + 6;
      repeat (3) tick();
      chk("t6_cyc_wait", wb_cyc_o, 1);
      #2;
      rst_core   = 1'b1;
      tx_v       = 1'b0;
      prev_rdata = '0;
      #1;
      chk("t6_cyc_async", wb_cyc_o, 0);
      chk("t6_stb_async", wb_stb_o, 0);
      chk("t6_stall_async", data_stall_o, 0);
      chk("t6_rdata_async", data_rdata_o, 0);
      repeat (2) tick();
      rst_core = 1'b0;
      repeat (4) tick();
      chk("t6_no_rvalid", data_rvalid_o, 0);
      start_tx(0, 4'h0, 32'h200, 32'h0, 0, 1, 32'h55AA_55AA);
      wait_tx();
      chk("t6_rvalid", data_rvalid_o, 1);
      chk("t6_rdata", data_rdata_o, 32'h55AA_55AA);
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
